spi_cmd_seq: RTL and testbench

Register-access command sequencer sitting directly upstream of the byte-level SPI engine (spi).
- Accepts single register read/write requests (address plus data) over a valid/ready port.
- Frames each request as one chip-select window: a header byte, then DATA_W/8 data bytes, MSB first.
- Feeds the bytes to spi one at a time and collects returned bytes into a read response.

---
 rtl/spi_pkg.sv | 34 +++
 rtl/spi_delay_cnt.sv | 28 ++
 rtl/spi_cmd_seq.sv | 209 ++++++++++++++++++++
 tb/tb_spi_cmd_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-access command sequencer.
package spi_pkg;

  // Sequencer states, one chip-select window per request.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    WAIT_RX,
    HOLD,
    RESP,
    GAP
  } state_t;

  // Bit 7 of the header byte: 1 marks a register read.
  localparam logic       SPI_RW_READ    = 1'b1;
  // Byte clocked out during the data phase of a read.
  localparam logic [7:0] SPI_DUMMY_BYTE = 8'h00;

  // Number of data bytes carried after the header.
  function automatic int spi_nbytes(input int data_w);
    return data_w / 8;
  endfunction

  // Largest of the three chip-select delays; sizes the shared delay counter.
  function automatic int spi_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/spi_delay_cnt.sv
// Loadable down-counter with a zero flag; times the setup, hold and idle gaps.
module spi_delay_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load takes priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spi_cmd_seq.sv
// Register read/write sequencer: frames each request as one chip-select window
// (header byte plus DATA_W/8 data bytes, MSB first) for the byte-level SPI engine.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; a valid output, once raised, stays high with stable data until taken.
module spi_cmd_seq
  import spi_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              spi_tx_valid,
  input  logic              spi_tx_ready,
  output logic [7:0]        spi_tx_data,
  input  logic              spi_rx_valid,
  input  logic [7:0]        spi_rx_data,
  output logic              spi_cs_n,
  output state_t            dbg_state
);

  localparam int NBYTES = spi_nbytes(DATA_W);
  localparam int IDX_W  = $clog2(NBYTES + 1) + 1;
  localparam int DMAX   = spi_max3(CS_SETUP, CS_HOLD, CS_IDLE);
  localparam int DLY_W  = (DMAX < 2) ? 1 : $clog2(DMAX + 1);

  // The counter is loaded with N-1 so that a gap of N cycles ends on its zero flag.
  localparam logic [DLY_W-1:0] SETUP_LD = DLY_W'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [DLY_W-1:0] HOLD_LD  = DLY_W'((CS_HOLD  > 0) ? CS_HOLD  - 1 : 0);
  localparam logic [DLY_W-1:0] IDLE_LD  = DLY_W'((CS_IDLE  > 0) ? CS_IDLE  - 1 : 0);

  state_t             state, state_nxt;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_shift;
  logic [DATA_W-1:0]  shift_nxt;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic [IDX_W-1:0]   idx;
  logic               cs_n_q;
  logic [7:0]         tx_byte;

  logic               req_fire, tx_fire, rx_fire, rsp_fire, last_byte;
  logic               cnt_load, cnt_dec, cnt_zero, frame_end;
  logic [DLY_W-1:0]   cnt_ld_val;

  assign req_ready    = (state == IDLE) && rst_n;
  assign spi_tx_valid = (state == SEND);
  assign rsp_valid    = (state == RESP);
  assign rsp_rdata    = rsp_rdata_q;
  assign spi_cs_n     = cs_n_q;
  assign spi_tx_data  = tx_byte;
  assign dbg_state    = state;

  assign req_fire  = req_valid && req_ready;
  assign tx_fire   = (state == SEND) && spi_tx_ready;
  assign rx_fire   = (state == WAIT_RX) && spi_rx_valid;
  assign rsp_fire  = (state == RESP) && rsp_ready;
  assign last_byte = (idx == IDX_W'(NBYTES));
  assign shift_nxt = (rdata_shift << 8) | DATA_W'(spi_rx_data);

  spi_delay_cnt #(.W(DLY_W)) u_delay_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and delay-counter control; zero-length gaps skip their state.
  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    cnt_dec    = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (CS_SETUP == 0) begin
            state_nxt = SEND;
          end else begin
            state_nxt  = SETUP;
            cnt_load   = 1'b1;
            cnt_ld_val = SETUP_LD;
          end
        end
      end
      SETUP: begin
        if (cnt_zero) state_nxt = SEND;
        else          cnt_dec   = 1'b1;
      end
      SEND: begin
        if (tx_fire) state_nxt = WAIT_RX;
      end
      WAIT_RX: begin
        if (rx_fire) begin
          if (!last_byte) begin
            state_nxt = SEND;
          end else if (CS_HOLD == 0) begin
            state_nxt = RESP;
            frame_end = 1'b1;
          end else begin
            state_nxt  = HOLD;
            cnt_load   = 1'b1;
            cnt_ld_val = HOLD_LD;
          end
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nxt = RESP;
          frame_end = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_fire) begin
          if (CS_IDLE == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt  = GAP;
            cnt_load   = 1'b1;
            cnt_ld_val = IDLE_LD;
          end
        end
      end
      GAP: begin
        if (cnt_zero) state_nxt = IDLE;
        else          cnt_dec   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte offered to the engine: header first, then write data MSB first or dummies.
  always_comb begin
    tx_byte = 8'h00;
    if (state == SEND) begin
      if (idx == '0) begin
        tx_byte = {(wr_q ? ~SPI_RW_READ : SPI_RW_READ), addr_q};
      end else if (!wr_q) begin
        tx_byte = SPI_DUMMY_BYTE;
      end else begin
        for (int k = 0; k < NBYTES; k++) begin
          if (idx == IDX_W'(NBYTES - k)) tx_byte = wdata_q[8*k +: 8];
        end
      end
    end
  end

  // Request latch, byte index, read shift register, chip select and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_shift <= '0;
      rsp_rdata_q <= '0;
      idx         <= '0;
      cs_n_q      <= 1'b1;
    end else begin
      if (req_fire) begin
        wr_q        <= req_write;
        addr_q      <= req_addr;
        wdata_q     <= req_wdata;
        rdata_shift <= '0;
        idx         <= '0;
        cs_n_q      <= 1'b0;
      end
      if (rx_fire) begin
        // The byte returned during the header carries no register data.
        if (!wr_q && (idx != '0)) rdata_shift <= shift_nxt;
        if (!last_byte)           idx         <= idx + 1'b1;
      end
      if (frame_end) begin
        cs_n_q <= 1'b1;
        // With no hold gap the final rx byte arrives in this same cycle.
        if (wr_q)                        rsp_rdata_q <= '0;
        else if (rx_fire && idx != '0)   rsp_rdata_q <= shift_nxt;
        else                             rsp_rdata_q <= rdata_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed plus randomized bench for spi_cmd_seq: an 8-bit and a 16-bit instance
// share one stimulus port, selected by sel; a slave model answers each tx byte.
module tb_spi_cmd_seq;
  import spi_pkg::*;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;
  localparam int BUDGET   = 200;

  // Clock/reset block
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus
  logic        sel;
  logic        req_valid, req_write, rsp_ready, tx_ready, rx_valid;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  rx_data;

  // Instance outputs
  logic        a_req_ready, a_rsp_valid, a_tx_valid, a_cs_n;
  logic [7:0]  a_rsp_rdata, a_tx_data;
  state_t      a_dbg;
  logic        b_req_ready, b_rsp_valid, b_tx_valid, b_cs_n;
  logic [15:0] b_rsp_rdata;
  logic [7:0]  b_tx_data;
  state_t      b_dbg;

  // Selected-instance view
  logic        m_req_ready, m_rsp_valid, m_tx_valid, m_cs_n;
  logic [31:0] m_rsp_rdata;
  logic [7:0]  m_tx_data;
  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_tx_valid  = sel ? b_tx_valid  : a_tx_valid;
  assign m_cs_n      = sel ? b_cs_n      : a_cs_n;
  assign m_tx_data   = sel ? b_tx_data   : a_tx_data;
  assign m_rsp_rdata = sel ? {16'h0, b_rsp_rdata} : {24'h0, a_rsp_rdata};

  spi_cmd_seq #(.ADDR_W(7), .DATA_W(8), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid && !sel),
    .req_ready    (a_req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata[7:0]),
    .rsp_valid    (a_rsp_valid),
    .rsp_ready    (rsp_ready && !sel),
    .rsp_rdata    (a_rsp_rdata),
    .spi_tx_valid (a_tx_valid),
    .spi_tx_ready (tx_ready),
    .spi_tx_data  (a_tx_data),
    .spi_rx_valid (rx_valid && !sel),
    .spi_rx_data  (rx_data),
    .spi_cs_n     (a_cs_n),
    .dbg_state    (a_dbg)
  );

  spi_cmd_seq #(.ADDR_W(7), .DATA_W(16), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) u_dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid && sel),
    .req_ready    (b_req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata[15:0]),
    .rsp_valid    (b_rsp_valid),
    .rsp_ready    (rsp_ready && sel),
    .rsp_rdata    (b_rsp_rdata),
    .spi_tx_valid (b_tx_valid),
    .spi_tx_ready (tx_ready),
    .spi_tx_data  (b_tx_data),
    .spi_rx_valid (rx_valid && sel),
    .spi_rx_data  (rx_data),
    .spi_cs_n     (b_cs_n),
    .dbg_state    (b_dbg)
  );

  // Scoreboard state
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] rx_q[$];
  int         last_rise[2] = '{-1, -1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one full register transaction on the selected instance, checked
  // against the framing rules (header, MSB-first data, setup/hold timing).
  task automatic run_txn(input bit w, input logic [6:0] a, input logic [31:0] wd,
                         input int tx_stall, input int rsp_stall, input bit spur);
    int         nb, n, cs_fall, last_rx;
    logic [7:0] exp_tx[$];
    logic [7:0] rx[$];
    logic [31:0] exp_rd;
    nb = sel ? 2 : 1;
    // Reference model: expected tx stream and read result.
    exp_tx.push_back({~w, a});
    for (int i = nb - 1; i >= 0; i--) exp_tx.push_back(w ? wd[8*i +: 8] : 8'h00);
    exp_rd = 32'h0;
    for (int i = 0; i <= nb; i++) begin
      if (rx_q.size() > 0) rx.push_back(rx_q.pop_front());
      else                 rx.push_back(8'($urandom_range(0, 255)));
      if (!w && i >= 1) exp_rd = (exp_rd << 8) | 32'(rx[i]);
    end

    n = 0;
    while (!m_req_ready && n < BUDGET) begin step(); n++; end
    check("req_ready_idle", 32'(m_req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0;
    cs_fall = cyc;
    check("cs_n_fall", 32'(m_cs_n), 32'd0);
    check("req_ready_busy", 32'(m_req_ready), 32'd0);
    if (last_rise[sel] >= 0) check("cs_idle_gap", 32'((cs_fall - last_rise[sel]) >= CS_IDLE), 32'd1);

    for (int i = 0; i <= nb; i++) begin
      n = 0;
      while (!m_tx_valid && n < BUDGET) begin step(); n++; end
      check("tx_valid", 32'(m_tx_valid), 32'd1);
      if (i == 0) check("cs_setup", 32'(cyc - cs_fall), 32'(CS_SETUP));
      if (i == 0 && tx_stall > 0) begin
        tx_ready = 1'b0;
        for (int s = 0; s < tx_stall; s++) begin
          if (spur && s == 0) begin rx_valid = 1'b1; rx_data = 8'hEE; end
          step();
          rx_valid = 1'b0;
          check("tx_valid_held", 32'(m_tx_valid), 32'd1);
          check("tx_data_held", 32'(m_tx_data), 32'(exp_tx[0]));
        end
      end
      check("tx_byte", 32'(m_tx_data), 32'(exp_tx[i]));
      tx_ready = 1'b1;
      if (spur) begin rx_valid = 1'b1; rx_data = 8'hEE; end
      step();
      rx_valid = 1'b0;
      check("one_outstanding", 32'(m_tx_valid), 32'd0);
      rx_valid = 1'b1; rx_data = rx[i];
      step();
      rx_valid = 1'b0;
      last_rx = cyc;
    end

    n = 0;
    while (!m_rsp_valid && n < BUDGET) begin step(); n++; end
    check("rsp_valid", 32'(m_rsp_valid), 32'd1);
    check("cs_hold", 32'(cyc - last_rx), 32'(CS_HOLD));
    check("cs_n_rise", 32'(m_cs_n), 32'd1);
    last_rise[sel] = cyc;
    for (int s = 0; s < rsp_stall; s++) begin
      req_valid = 1'b1;
      step();
      check("rsp_valid_held", 32'(m_rsp_valid), 32'd1);
      check("rsp_rdata_held", m_rsp_rdata, exp_rd);
      check("req_ready_resp", 32'(m_req_ready), 32'd0);
    end
    req_valid = 1'b0;
    check("rsp_rdata", m_rsp_rdata, exp_rd);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_cleared", 32'(m_rsp_valid), 32'd0);
    check("req_ready_gap", 32'(m_req_ready), 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    sel = 1'b0; rst_n = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;

    // 1. asynchronous reset, then quiet idle after release
    #3 rst_n = 1'b0;
    #1;
    check("rst_cs_n_a", 32'(a_cs_n), 32'd1);
    check("rst_cs_n_b", 32'(b_cs_n), 32'd1);
    check("rst_tx_valid", 32'({a_tx_valid, b_tx_valid}), 32'd0);
    check("rst_rsp_valid", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
    check("rst_req_ready", 32'({a_req_ready, b_req_ready}), 32'd0);
    check("rst_tx_data", 32'({a_tx_data, b_tx_data}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("post_rst_req_ready", 32'({a_req_ready, b_req_ready}), 32'h3);
    check("post_rst_idle_bus", 32'({a_cs_n, b_cs_n, a_tx_valid, b_tx_valid}), 32'hC);

    // 2. write 0x15 <= 0xA5
    run_txn(1'b1, 7'h15, 32'h0000_00A5, 0, 0, 1'b0);

    // 3. read 0x3C, slave returns 0xFF then 0x5A
    rx_q = '{8'hFF, 8'h5A};
    run_txn(1'b0, 7'h3C, 32'h0, 0, 0, 1'b0);

    // 4. backpressure on header and response
    run_txn(1'b0, 7'h3C, 32'h0, 5, 3, 1'b0);

    // 5. 16-bit read of 0x01
    sel = 1'b1;
    rx_q = '{8'h77, 8'h12, 8'h34};
    run_txn(1'b0, 7'h01, 32'h0, 0, 0, 1'b0);
    sel = 1'b0;

    // 6a. spurious rx pulses in IDLE and SEND are ignored
    rx_valid = 1'b1; rx_data = 8'hEE;
    step();
    rx_valid = 1'b0;
    check("spur_idle_ready", 32'(m_req_ready), 32'd1);
    check("spur_idle_cs_n", 32'(m_cs_n), 32'd1);
    rx_q = '{8'h01, 8'hC3};
    run_txn(1'b0, 7'h2A, 32'h0, 2, 0, 1'b1);

    // 6b. reset while waiting for the header rx byte
    n = 0;
    while (!m_req_ready && n < BUDGET) begin step(); n++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h22;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!m_tx_valid && n < BUDGET) begin step(); n++; end
    tx_ready = 1'b1;
    step();
    check("in_wait_rx", 32'(a_dbg), 32'(WAIT_RX));
    #2 rst_n = 1'b0;
    #1;
    check("midframe_cs_n", 32'(m_cs_n), 32'd1);
    check("midframe_tx_valid", 32'(m_tx_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_rsp_valid || !m_cs_n) seen = 1'b1;
    end
    check("no_stale_rsp", 32'(seen), 32'd0);
    last_rise[0] = -1;
    last_rise[1] = -1;
    run_txn(1'b1, 7'h40, 32'h0000_005C, 0, 0, 1'b0);

    // Randomized transactions on both widths
    for (int k = 0; k < 24; k++) begin
      sel = 1'($urandom_range(0, 1));
      run_txn(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
